// File: rtl/kp_pkg.sv
// ---------------------------------------------------------------------------
// kp_pkg
// Shared types and helpers for the parametrised keypad scanner.
//   kp_state_e : scan FSM states (DRIVE -> SAMPLE -> EVAL -> DRIVE ...)
//   kp_event_t : one queued key event {rel, code}; code is sized for the
//                largest supported matrix (8x8) and trimmed by the top
//   kp_idx_w   : minimum index width for n items, never less than 1
//   kp_cw      : event code width for a ROWS x COLS matrix
// ---------------------------------------------------------------------------
package kp_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } kp_state_e;

  // 8 x 8 keys is the largest matrix, so 6 code bits always suffice.
  localparam int KP_CODE_MAX_W = 6;

  typedef struct packed {
    logic                     rel;   // 1 = release, 0 = press
    logic [KP_CODE_MAX_W-1:0] code;  // row*COLS + col
  } kp_event_t;

  // Width needed to index n items; a 1-item or 2-item range still gets 1 bit.
  function automatic int kp_idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Event code width for the matrix.
  function automatic int kp_cw(input int rows, input int cols);
    return kp_idx_w(rows * cols);
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// ---------------------------------------------------------------------------
// kp_event_fifo
// First-word-fall-through event queue. The head entry is presented on
// head_data whenever valid = 1; a pop advances to the next entry, which is
// visible the following cycle.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data (accepted when not full, or when full and
//                a pop happens in the same cycle)
//   pop        : advance the head; ignored while empty
//   head_data  : current head entry
//   valid      : queue non-empty (registered)
//   full       : queue full (registered)
// ---------------------------------------------------------------------------
module kp_event_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          valid,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          valid_r;
  logic          full_r;
  logic          do_pop_s;
  logic          do_push_s;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    // A pop in the same cycle frees the slot a full-queue push needs.
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
      full_r  <= (count_nxt_s == FULL_CNT);
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign valid     = valid_r;
  assign full      = full_r;

endmodule

// File: rtl/kp_scan_fifo.sv
// ---------------------------------------------------------------------------
// kp_scan_fifo
// Scans a ROWS x COLS key matrix one column at a time, debounces every key
// independently and queues press/release events in a FWFT FIFO.
//   CLK, RST_N : scan clock, async active-low reset
//   K_I        : row sense, 0 = key closed on the driven column
//   K_O_ctl    : column control to the open-drain wrapper, 0 = drive low
//   ev_valid   : event queue non-empty
//   ev_ready   : pop strobe (ignored while empty)
//   ev_code    : head event key index row*COLS+col
//   ev_release : head event kind, 1 = release
//   key_down   : OR of all debounced key states
//   ovf        : sticky, an event was dropped on a full queue
//   ovf_clr    : clears ovf (wins over a same-cycle set)
// ---------------------------------------------------------------------------
module kp_scan_fifo
  import kp_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 2,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [ROWS-1:0]               K_I,
  output logic [COLS-1:0]               K_O_ctl,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [kp_cw(ROWS, COLS)-1:0]  ev_code,
  output logic                          ev_release,
  output logic                          key_down,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int NK   = ROWS * COLS;
  localparam int CW   = kp_cw(ROWS, COLS);
  localparam int RW   = kp_idx_w(ROWS);
  localparam int CLW  = kp_idx_w(COLS);
  localparam int SW   = kp_idx_w(SETTLE + 1);
  localparam int CNTW = kp_idx_w(DEBOUNCE + 1);

  // Scan FSM state
  kp_state_e       state_r;
  logic [SW-1:0]   settle_r;
  logic [CLW-1:0]  col_r;
  logic [RW-1:0]   row_r;
  logic [COLS-1:0] k_o_ctl_r;
  logic [ROWS-1:0] row_smp_r;   // 1 = closed

  // Debounce state
  logic            stable_r [NK];
  logic [CNTW-1:0] cnt_r    [NK];
  logic            key_down_r;
  logic            ovf_r;

  // Evaluation datapath
  logic [CLW-1:0]  col_nxt_s;
  int              key_idx_s;
  logic            eval_s;
  logic            raw_s;
  logic            sel_stable_s;
  logic [CNTW-1:0] sel_cnt_s;
  logic            fire_s;
  kp_event_t       push_evt_s;
  logic            any_down_s;

  // FIFO interface
  kp_event_t       head_evt_s;
  logic            fifo_valid_s;
  logic            fifo_full_s;
  logic            drop_s;
  logic            unused_code_s;

  // Next column and the debounce decision for the key under evaluation.
  always_comb begin
    col_nxt_s    = (col_r == CLW'(COLS - 1)) ? '0 : col_r + CLW'(1);
    key_idx_s    = int'(row_r) * COLS + int'(col_r);
    eval_s       = (state_r == EVAL);
    raw_s        = row_smp_r[row_r];
    sel_stable_s = 1'b0;
    sel_cnt_s    = '0;
    any_down_s   = 1'b0;
    for (int k = 0; k < NK; k++) begin
      sel_stable_s = (k == key_idx_s) ? stable_r[k] : sel_stable_s;
      sel_cnt_s    = (k == key_idx_s) ? cnt_r[k]    : sel_cnt_s;
      any_down_s   = any_down_s | stable_r[k];
    end
    // Only one key is evaluated per cycle, so at most one push per cycle.
    fire_s          = eval_s && (raw_s != sel_stable_s) &&
                      (sel_cnt_s == CNTW'(DEBOUNCE - 1));
    push_evt_s.rel  = ~raw_s;
    push_evt_s.code = KP_CODE_MAX_W'(key_idx_s);
    // A full queue only has room if the head leaves this same cycle.
    drop_s          = fire_s && fifo_full_s && !(ev_ready && fifo_valid_s);
  end

  // Scan FSM: column drive, settle, row sampling and row-by-row evaluation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= DRIVE;
      settle_r  <= '0;
      col_r     <= '0;
      row_r     <= '0;
      k_o_ctl_r <= ~COLS'(1);
      row_smp_r <= '0;
    end else begin
      case (state_r)
        DRIVE: begin
          if (settle_r == SW'(SETTLE - 1)) begin
            settle_r <= '0;
            state_r  <= SAMPLE;
          end else begin
            settle_r <= settle_r + SW'(1);
          end
        end
        SAMPLE: begin
          row_smp_r <= ~K_I;
          row_r     <= '0;
          state_r   <= EVAL;
        end
        EVAL: begin
          if (row_r == RW'(ROWS - 1)) begin
            // The column only changes on the way back into DRIVE.
            row_r     <= '0;
            col_r     <= col_nxt_s;
            k_o_ctl_r <= ~(COLS'(1) << col_nxt_s);
            state_r   <= DRIVE;
          end else begin
            row_r <= row_r + RW'(1);
          end
        end
        default: begin
          state_r   <= DRIVE;
          settle_r  <= '0;
          col_r     <= '0;
          row_r     <= '0;
          k_o_ctl_r <= ~COLS'(1);
        end
      endcase
    end
  end

  // Per-key debounce: count consecutive disagreeing samples, flip on the last.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NK; k++) begin
        stable_r[k] <= 1'b0;
        cnt_r[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (eval_s && (k == key_idx_s)) begin
          if (raw_s == stable_r[k]) begin
            cnt_r[k] <= '0;
          end else if (fire_s) begin
            // State follows the key even when the event is dropped.
            stable_r[k] <= raw_s;
            cnt_r[k]    <= '0;
          end else begin
            cnt_r[k] <= cnt_r[k] + CNTW'(1);
          end
        end
      end
    end
  end

  // Aggregate key state and the sticky overflow flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_down_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      key_down_r <= any_down_s;
      if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  kp_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(kp_event_t))
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (fire_s),
    .push_data (push_evt_s),
    .pop       (ev_ready),
    .head_data (head_evt_s),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s)
  );

  // Code bits above CW are always zero for smaller matrices.
  assign unused_code_s = ^head_evt_s.code;

  assign K_O_ctl    = k_o_ctl_r;
  assign ev_valid   = fifo_valid_s;
  assign ev_code    = head_evt_s.code[CW-1:0];
  assign ev_release = head_evt_s.rel;
  assign key_down   = key_down_r;
  assign ovf        = ovf_r;

endmodule
